flag_sequencer: RTL and testbench
=================================

FLAG_SEQUENCER -- requirements
Module: flag_sequencer

Interface
REQ-001 Parameter FLAG_X, default 11'd560: fixed topLeftX of the 32x32 flag bitmap.
REQ-002 Parameter POLE_BOTTOM_Y, default 11'd416: topLeftY at start of rise.
REQ-003 Parameter POLE_TOP_Y, default 11'd64: topLeftY at end of rise; SHALL be less than POLE_BOTTOM_Y.
REQ-004 Parameter RISE_STEP, default 4: pixels the flag moves up per frame tick.
REQ-005 Parameter WAVE_PERIOD, default 8: frame ticks between mirrorX toggles.
REQ-006 Parameter BLINK_HALF, default 8: frame ticks per blink half-period.
REQ-007 Parameter BLINK_COUNT, default 4: visible/invisible toggle pairs in CAPTURED.
REQ-008 clk  in  1  system clock; the only clock.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 startOfFrame  in  1  one-cycle pulse per VGA frame (frame tick).
REQ-011 levelStart  in  1  one-cycle pulse that starts the flag sequence.
REQ-012 playerHit  in  1  player/flag collision, level-sensitive, any cycle.
REQ-013 topLeftX  out  11  flag top-left X, constant FLAG_X.
REQ-014 topLeftY  out  11  flag top-left Y.
REQ-015 flagVisible  out  1  gates the bitmap's InsideRectangle.
REQ-016 mirrorX  out  1  horizontal flip select for wave animation.
REQ-017 levelDone  out  1  one-cycle pulse when the sequence completes.
REQ-018 state  out  3  current state encoding, for debug.

Function
REQ-019 States: IDLE, RISE, WAVE, CAPTURED, DONE; all transitions are registered and occur one cycle after the triggering input.
REQ-020 IDLE: flagVisible=0. levelStart -> RISE with topLeftY=POLE_BOTTOM_Y, mirrorX=0.
REQ-021 RISE: flagVisible=1. Each frame tick, topLeftY decreases by RISE_STEP, clamped so it never goes below POLE_TOP_Y.
REQ-022 RISE -> WAVE on the tick where topLeftY reaches POLE_TOP_Y; playerHit is ignored in RISE.
REQ-023 WAVE: flagVisible=1, topLeftY=POLE_TOP_Y. mirrorX toggles on every WAVE_PERIOD-th frame tick; the tick counter clears on entry.
REQ-024 WAVE: playerHit=1 in any cycle -> CAPTURED on the next cycle; the tick counter clears and flagVisible=1.
REQ-025 CAPTURED: flagVisible inverts every BLINK_HALF ticks. After 2*BLINK_COUNT inversions (flagVisible ends at 1) -> DONE; playerHit is ignored.
REQ-026 DONE: flagVisible=0. levelDone=1 for exactly the single cycle after entry. The block then waits for levelStart.
REQ-027 levelStart in any state, including mid-RISE or CAPTURED, restarts RISE per REQ-020 and takes priority over playerHit and ticks in the same cycle.
REQ-028 startOfFrame coincident with a state entry is not counted in the new state.
REQ-029 Tick counters are ceil(log2(max(WAVE_PERIOD, BLINK_HALF)))+1 bits wide and wrap to 0 at their terminal count.
REQ-030 topLeftY arithmetic uses 12 bits signed internally so underflow cannot occur before clamping.

Reset
REQ-031 On reset: state=IDLE, topLeftX=FLAG_X, topLeftY=POLE_BOTTOM_Y, flagVisible=0, mirrorX=0, levelDone=0, all counters 0.
REQ-032 reset overrides levelStart and every other input in the same cycle.

Structure
REQ-033 Package flag_seq_pkg holds the state enum typedef and the default geometry and timing constants.
REQ-034 One sub-module, frame_tick_counter, counts startOfFrame pulses to a terminal count, with clear input and a terminal-pulse output; it is instantiated once and shared by WAVE and CAPTURED.
REQ-035 All outputs are registered; no combinational path from any input to any output.

Verification
REQ-036 reset, then levelStart, then 88 ticks: topLeftY steps 416->412->...->64, and the state is WAVE after tick 88.
REQ-037 In WAVE, 24 ticks: mirrorX toggles at ticks 8, 16 and 24.
REQ-038 playerHit in WAVE: CAPTURED next cycle; flagVisible toggles every 8 ticks for 64 ticks; then DONE with levelDone high for exactly 1 cycle and flagVisible=0.
REQ-039 playerHit during RISE: no state change; rise continues to 64.
REQ-040 levelStart mid-CAPTURED, coincident with startOfFrame: next cycle RISE, topLeftY=416, flagVisible=1, levelDone stays 0.
REQ-041 reset asserted in WAVE together with levelStart: next cycle IDLE, all outputs at reset values.

Source files
------------

// File: rtl/flag_seq_pkg.sv
// Shared state encoding and default geometry/timing for the flag sequencer.
package flag_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RISE     = 3'd1,
    WAVE     = 3'd2,
    CAPTURED = 3'd3,
    DONE     = 3'd4
  } flag_state_t;

  localparam logic [10:0] DEF_FLAG_X        = 11'd560;
  localparam logic [10:0] DEF_POLE_BOTTOM_Y = 11'd416;
  localparam logic [10:0] DEF_POLE_TOP_Y    = 11'd64;
  localparam int          DEF_RISE_STEP     = 4;
  localparam int          DEF_WAVE_PERIOD   = 8;
  localparam int          DEF_BLINK_HALF    = 8;
  localparam int          DEF_BLINK_COUNT   = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/flag_sequencer_tick_counter.sv
// Counts frame ticks up to a run-time terminal count and flags the wrapping tick.
module frame_tick_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         clear,
  input  logic [W-1:0] terminal,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] ONE = W'(1);

  // The wrapping tick is reported raw; the owner decides whether it applies.
  assign wrap = tick && (count == (terminal - ONE));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (tick) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/flag_sequencer.sv
// Level-end flag animation: rise up the pole, wave, blink when captured, then signal done.
module flag_sequencer
  import flag_seq_pkg::*;
#(
  parameter logic [10:0] FLAG_X        = DEF_FLAG_X,
  parameter logic [10:0] POLE_BOTTOM_Y = DEF_POLE_BOTTOM_Y,
  parameter logic [10:0] POLE_TOP_Y    = DEF_POLE_TOP_Y,
  parameter int          RISE_STEP     = DEF_RISE_STEP,
  parameter int          WAVE_PERIOD   = DEF_WAVE_PERIOD,
  parameter int          BLINK_HALF    = DEF_BLINK_HALF,
  parameter int          BLINK_COUNT   = DEF_BLINK_COUNT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        levelStart,
  input  logic        playerHit,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        flagVisible,
  output logic        mirrorX,
  output logic        levelDone,
  output logic [2:0]  state
);

  localparam int CNT_W   = $clog2(max2(WAVE_PERIOD, BLINK_HALF)) + 1;
  localparam int BLINK_W = $clog2(2 * BLINK_COUNT) + 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_COUNT - 1);
  localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

  flag_state_t        state_q, state_d;
  logic [10:0]        y_q, y_d;
  logic               vis_q, vis_d;
  logic               mirror_q, mirror_d;
  logic               done_q, done_d;
  logic [BLINK_W-1:0] blink_q, blink_d;

  logic [CNT_W-1:0]   terminal;
  logic [CNT_W-1:0]   tick_count;
  logic               tick_wrap;
  logic               tick_clear;
  logic signed [11:0] y_dec;

  // The counter only runs in WAVE/CAPTURED and restarts on every entry to them,
  // so a tick coinciding with an entry is never counted in the new state.
  assign tick_clear = levelStart
                   || ((state_q == WAVE) && playerHit)
                   || !((state_q == WAVE) || (state_q == CAPTURED));
  assign terminal   = (state_q == CAPTURED) ? CNT_W'(BLINK_HALF) : CNT_W'(WAVE_PERIOD);

  frame_tick_counter #(.W(CNT_W)) u_ticks (
    .clk      (clk),
    .reset    (reset),
    .tick     (startOfFrame),
    .clear    (tick_clear),
    .terminal (terminal),
    .count    (tick_count),
    .wrap     (tick_wrap)
  );

  assign y_dec = $signed({1'b0, y_q}) - $signed(12'(RISE_STEP));

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    vis_d    = vis_q;
    mirror_d = mirror_q;
    done_d   = 1'b0;
    blink_d  = blink_q;
    if (levelStart) begin
      state_d  = RISE;
      y_d      = POLE_BOTTOM_Y;
      vis_d    = 1'b1;
      mirror_d = 1'b0;
      blink_d  = '0;
    end else begin
      case (state_q)
        RISE: begin
          if (startOfFrame) begin
            if (y_dec <= $signed({1'b0, POLE_TOP_Y})) begin
              y_d     = POLE_TOP_Y;
              state_d = WAVE;
            end else begin
              y_d = y_dec[10:0];
            end
          end
        end
        WAVE: begin
          if (playerHit) begin
            state_d = CAPTURED;
            vis_d   = 1'b1;
            blink_d = '0;
          end else if (tick_wrap) begin
            mirror_d = ~mirror_q;
          end
        end
        CAPTURED: begin
          // The final inversion would restore visibility; DONE hides the flag instead.
          if (tick_wrap) begin
            if (blink_q == BLINK_LAST) begin
              state_d = DONE;
              vis_d   = 1'b0;
              done_d  = 1'b1;
              blink_d = '0;
            end else begin
              vis_d   = ~vis_q;
              blink_d = blink_q + BLINK_ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      y_q      <= POLE_BOTTOM_Y;
      vis_q    <= 1'b0;
      mirror_q <= 1'b0;
      done_q   <= 1'b0;
      blink_q  <= '0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      vis_q    <= vis_d;
      mirror_q <= mirror_d;
      done_q   <= done_d;
      blink_q  <= blink_d;
    end
  end

  assign topLeftX    = FLAG_X;
  assign topLeftY    = y_q;
  assign flagVisible = vis_q;
  assign mirrorX     = mirror_q;
  assign levelDone   = done_q;
  assign state       = state_q;

endmodule

// File: tb/tb_flag_sequencer.sv
// Directed bench for flag_sequencer: rise, wave, capture/blink, restart and reset priority.
module tb_flag_sequencer;

  logic        clk;
  logic        reset;
  logic        startOfFrame;
  logic        levelStart;
  logic        playerHit;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        flagVisible;
  logic        mirrorX;
  logic        levelDone;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_RISE = 3'd1, S_WAVE = 3'd2,
                         S_CAPT = 3'd3, S_DONE = 3'd4;

  flag_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .levelStart   (levelStart),
    .playerHit    (playerHit),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .flagVisible  (flagVisible),
    .mirrorX      (mirrorX),
    .levelDone    (levelDone),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: inputs set on the falling edge, released just after the rising edge.
  task automatic applyStimulus(input logic sof, input logic ls, input logic hit, input logic rst);
    @(negedge clk);
    startOfFrame = sof;
    levelStart   = ls;
    playerHit    = hit;
    reset        = rst;
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
    levelStart   = 1'b0;
    playerHit    = 1'b0;
    reset        = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [2:0] st, input logic [10:0] y,
                          input logic vis, input logic mir, input logic done);
    checkOutput({tag, ".state"}, 32'(state), 32'(st));
    checkOutput({tag, ".topLeftY"}, 32'(topLeftY), 32'(y));
    checkOutput({tag, ".flagVisible"}, 32'(flagVisible), 32'(vis));
    checkOutput({tag, ".mirrorX"}, 32'(mirrorX), 32'(mir));
    checkOutput({tag, ".levelDone"}, 32'(levelDone), 32'(done));
  endtask

  initial begin
    int exp_y;
    startOfFrame = 1'b0;
    levelStart   = 1'b0;
    playerHit    = 1'b0;
    reset        = 1'b0;

    // Reset values
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkAll("reset", S_IDLE, 11'd416, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.topLeftX", 32'(topLeftX), 32'd560);

    ticks(2);
    checkAll("idle_ticks", S_IDLE, 11'd416, 1'b0, 1'b0, 1'b0);

    // Start coincident with a tick: tick not counted in RISE
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkAll("start", S_RISE, 11'd416, 1'b1, 1'b0, 1'b0);

    for (int i = 1; i <= 88; i++) begin
      if (i == 20) begin
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("rise_hit.state", 32'(state), 32'(S_RISE));
        checkOutput("rise_hit.topLeftY", 32'(topLeftY), 32'(416 - 4 * 19));
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      end else begin
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      end
      exp_y = 416 - 4 * i;
      if (exp_y < 64) exp_y = 64;
      checkOutput($sformatf("rise%0d.topLeftY", i), 32'(topLeftY), 32'(exp_y));
      checkOutput($sformatf("rise%0d.state", i), 32'(state), (i == 88) ? 32'(S_WAVE) : 32'(S_RISE));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkAll("wave_entry", S_WAVE, 11'd64, 1'b1, 1'b0, 1'b0);

    // Wave: mirror toggles on ticks 8, 16, 24
    for (int i = 1; i <= 24; i++) begin
      ticks(1);
      checkOutput($sformatf("wave%0d.mirrorX", i), 32'(mirrorX), 32'((i / 8) % 2));
    end
    checkAll("wave_end", S_WAVE, 11'd64, 1'b1, 1'b1, 1'b0);

    // Capture with coincident tick
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkAll("capture", S_CAPT, 11'd64, 1'b1, 1'b1, 1'b0);

    for (int i = 1; i <= 63; i++) begin
      ticks(1);
      checkOutput($sformatf("blink%0d.flagVisible", i), 32'(flagVisible), 32'(((i / 8) % 2) == 0));
      checkOutput($sformatf("blink%0d.state", i), 32'(state), 32'(S_CAPT));
      if (i == 30) begin
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("capt_hit.state", 32'(state), 32'(S_CAPT));
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkAll("done_entry", S_DONE, 11'd64, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkAll("done_hold", S_DONE, 11'd64, 1'b0, 1'b1, 1'b0);
    ticks(3);
    checkAll("done_wait", S_DONE, 11'd64, 1'b0, 1'b1, 1'b0);

    // Restart from DONE, then abort mid-CAPTURED with a coincident tick
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkAll("restart", S_RISE, 11'd416, 1'b1, 1'b0, 1'b0);
    ticks(88);
    ticks(8);
    checkAll("wave2", S_WAVE, 11'd64, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(20);
    checkAll("capt2", S_CAPT, 11'd64, 1'b1, 1'b1, 1'b0);
    ticks(4);
    checkOutput("capt2_24.flagVisible", 32'(flagVisible), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkAll("abort_capt", S_RISE, 11'd416, 1'b1, 1'b0, 1'b0);
    ticks(1);
    checkOutput("abort_rise1.topLeftY", 32'(topLeftY), 32'd412);

    // Reset beats levelStart in WAVE
    ticks(87);
    ticks(8);
    checkAll("wave3", S_WAVE, 11'd64, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkAll("reset_wave", S_IDLE, 11'd416, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_wave.topLeftX", 32'(topLeftX), 32'd560);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
